// File: rtl/idea_pkg.sv
// Shared types and constants for the iterative IDEA block engine.
package idea_pkg;

  localparam int WORD_W  = 16;
  localparam int BLOCK_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OTX,
    DONE
  } state_e;

  function automatic int subkey_count(input int rounds);
    return 6 * rounds + 4;
  endfunction

endpackage

// File: rtl/inmultire.sv
// Combinational multiply modulo 2^16+1; a zero operand stands for 2^16 and a 2^16 result is returned as 0.
// Zero latency, no handshake.
module inmultire
  import idea_pkg::*;
(
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
  output logic [WORD_W-1:0] prod
);

  logic [2*WORD_W-1:0] full;
  logic [WORD_W-1:0]   lo;
  logic [WORD_W-1:0]   hi;

  always_comb begin
    full = (2*WORD_W)'(op_a) * (2*WORD_W)'(op_b);
    lo   = full[WORD_W-1:0];
    hi   = full[2*WORD_W-1:WORD_W];
    if (op_a == '0) begin
      // 2^16 is -1 mod 2^16+1, so the product reduces to 1 - other operand
      prod = WORD_W'(1) - op_b;
    end else if (op_b == '0) begin
      prod = WORD_W'(1) - op_a;
    end else begin
      prod = lo - hi + {{(WORD_W-1){1'b0}}, (lo < hi)};
    end
  end

endmodule

// File: rtl/idea_round_ctrl.sv
// Iterative IDEA engine: one shared modular multiplier, 6 cycles per round plus 4 output cycles.
// out_valid rises 6*ROUNDS+4 edges after accept; result held in DONE until out_ready, in_ready low while busy or holding.
module idea_round_ctrl
  import idea_pkg::*;
#(
  parameter int ROUNDS = 8,
  parameter int KIDX_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_block,
  output logic [KIDX_W-1:0]  key_idx,
  input  logic [15:0]        key_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_block,
  output logic               busy
);

  localparam logic [3:0]        LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [KIDX_W-1:0] OTX_BASE   = KIDX_W'(subkey_count(ROUNDS) - 4);
  localparam logic [KIDX_W-1:0] ROUND_KEYS = KIDX_W'(6);

  state_e state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [2:0] step_q, step_d;

  logic [WORD_W-1:0] x1_q, x1_d, x2_q, x2_d, x3_q, x3_d, x4_q, x4_d;
  logic [WORD_W-1:0] y1_q, y1_d, y2_q, y2_d, y3_q, y3_d, y4_q, y4_d;
  logic [WORD_W-1:0] t3_q, t3_d;
  logic [WORD_W-1:0] o1_q, o1_d, o2_q, o2_d, o3_q, o3_d;
  logic [BLOCK_W-1:0] out_block_q, out_block_d;

  logic [WORD_W-1:0] mul_a, mul_p, add_a, add_s, t6;

  inmultire u_mul (
    .op_a (mul_a),
    .op_b (key_data),
    .prod (mul_p)
  );

  // Operand selection for the single multiplier and the key adder.
  always_comb begin
    mul_a = '0;
    add_a = '0;
    if (state_q == RUN) begin
      case (step_q)
        3'd0:    mul_a = x1_q;
        3'd1:    add_a = x2_q;
        3'd2:    add_a = x3_q;
        3'd3:    mul_a = x4_q;
        3'd4:    mul_a = y1_q ^ y3_q;
        3'd5:    mul_a = (y2_q ^ y4_q) + t3_q;
        default: mul_a = '0;
      endcase
    end else if (state_q == OTX) begin
      // Output transform undoes the middle-word swap of the last round
      case (step_q)
        3'd0:    mul_a = x1_q;
        3'd1:    add_a = x3_q;
        3'd2:    add_a = x2_q;
        3'd3:    mul_a = x4_q;
        default: mul_a = '0;
      endcase
    end
    add_s = add_a + key_data;
    t6    = t3_q + mul_p;
  end

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    step_d      = step_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    x3_d        = x3_q;
    x4_d        = x4_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    y3_d        = y3_q;
    y4_d        = y4_q;
    t3_d        = t3_q;
    o1_d        = o1_q;
    o2_d        = o2_q;
    o3_d        = o3_q;
    out_block_d = out_block_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          {x1_d, x2_d, x3_d, x4_d} = in_block;
          round_d = '0;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        case (step_q)
          3'd0: y1_d = mul_p;
          3'd1: y2_d = add_s;
          3'd2: y3_d = add_s;
          3'd3: y4_d = mul_p;
          3'd4: t3_d = mul_p;
          3'd5: begin
            x1_d = y1_q ^ mul_p;
            x2_d = y3_q ^ mul_p;
            x3_d = y2_q ^ t6;
            x4_d = y4_q ^ t6;
          end
          default: ;
        endcase
        if (step_q == 3'd5) begin
          step_d = '0;
          if (round_q == LAST_ROUND) begin
            round_d = '0;
            state_d = OTX;
          end else begin
            round_d = round_q + 4'd1;
          end
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      OTX: begin
        case (step_q)
          3'd0: o1_d = mul_p;
          3'd1: o2_d = add_s;
          3'd2: o3_d = add_s;
          default: ;
        endcase
        if (step_q == 3'd3) begin
          out_block_d = {o1_q, o2_q, o3_q, mul_p};
          step_d      = '0;
          state_d     = DONE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_q     <= '0;
      step_q      <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      x3_q        <= '0;
      x4_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      y3_q        <= '0;
      y4_q        <= '0;
      t3_q        <= '0;
      o1_q        <= '0;
      o2_q        <= '0;
      o3_q        <= '0;
      out_block_q <= '0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      step_q      <= step_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      x3_q        <= x3_d;
      x4_q        <= x4_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      y3_q        <= y3_d;
      y4_q        <= y4_d;
      t3_q        <= t3_d;
      o1_q        <= o1_d;
      o2_q        <= o2_d;
      o3_q        <= o3_d;
      out_block_q <= out_block_d;
    end
  end

  // Outputs decode straight from the state so reset shows on them without a clock edge.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == OTX);
    out_block = out_block_q;
    key_idx   = '0;
    if (state_q == RUN) begin
      key_idx = KIDX_W'(round_q) * ROUND_KEYS + KIDX_W'(step_q);
    end else if (state_q == OTX) begin
      key_idx = OTX_BASE + KIDX_W'(step_q);
    end
  end

endmodule

// File: tb/tb_idea_round_ctrl.sv
// Bench for idea_round_ctrl: two instances (8 rounds and 1 round) checked against a behavioural IDEA model.
module tb_idea_round_ctrl;

  localparam logic [127:0] STD_KEY = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
  localparam logic [63:0]  STD_PT  = 64'h0000_0001_0002_0003;
  localparam logic [63:0]  STD_CT  = 64'h11FB_ED2B_0198_6DE5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel1 = 1'b0;
  logic        tb_in_valid = 1'b0;
  logic [63:0] tb_in_block = '0;
  logic        tb_out_ready = 1'b0;

  logic        in_ready8, out_valid8, busy8, in_ready1, out_valid1, busy1;
  logic [5:0]  key_idx8, key_idx1;
  logic [15:0] key_data8, key_data1;
  logic [63:0] out_block8, out_block1;

  logic [15:0] ks8 [0:63];
  logic [15:0] ks1 [0:63];
  logic [15:0] ek  [0:63];
  logic [15:0] dk  [0:63];

  assign key_data8 = ks8[key_idx8];
  assign key_data1 = ks1[key_idx1];

  idea_round_ctrl #(.ROUNDS(8), .KIDX_W(6)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(tb_in_valid & ~sel1), .in_ready(in_ready8),
    .in_block(tb_in_block), .key_idx(key_idx8), .key_data(key_data8), .out_valid(out_valid8),
    .out_ready(tb_out_ready), .out_block(out_block8), .busy(busy8)
  );

  idea_round_ctrl #(.ROUNDS(1), .KIDX_W(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(tb_in_valid & sel1), .in_ready(in_ready1),
    .in_block(tb_in_block), .key_idx(key_idx1), .key_data(key_data1), .out_valid(out_valid1),
    .out_ready(tb_out_ready), .out_block(out_block1), .busy(busy1)
  );

  logic        v_in_ready, v_out_valid, v_busy;
  logic [5:0]  v_key_idx;
  logic [63:0] v_out_block;
  assign v_in_ready  = sel1 ? in_ready1  : in_ready8;
  assign v_out_valid = sel1 ? out_valid1 : out_valid8;
  assign v_busy      = sel1 ? busy1      : busy8;
  assign v_key_idx   = sel1 ? key_idx1   : key_idx8;
  assign v_out_block = sel1 ? out_block1 : out_block8;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  function automatic logic [15:0] mmul(input logic [15:0] a, input logic [15:0] b);
    longint x, y, r;
    x = (a == 16'd0) ? 65536 : longint'(a);
    y = (b == 16'd0) ? 65536 : longint'(b);
    r = (x * y) % 65537;
    return (r == 65536) ? 16'd0 : 16'(r);
  endfunction

  function automatic logic [15:0] minv(input logic [15:0] a);
    longint base, res;
    int e;
    base = (a == 16'd0) ? 65536 : longint'(a);
    res = 1;
    e = 65535;
    while (e > 0) begin
      if (e % 2 == 1) res = (res * base) % 65537;
      base = (base * base) % 65537;
      e = e / 2;
    end
    return (res == 65536) ? 16'd0 : 16'(res);
  endfunction

  task automatic gen_enc(input logic [127:0] key);
    logic [127:0] k;
    k = key;
    for (int i = 0; i < 64; i++) begin
      ek[i] = k[127-16*(i%8) -: 16];
      if (i % 8 == 7) k = {k[102:0], k[127:103]};
    end
  endtask

  task automatic gen_dec(input int rounds);
    int base;
    for (int i = 0; i < 64; i++) dk[i] = '0;
    for (int r = 0; r < rounds; r++) begin
      base = 6 * (rounds - r);
      dk[6*r]   = minv(ek[base]);
      dk[6*r+3] = minv(ek[base+3]);
      if (r == 0) begin
        dk[6*r+1] = 16'd0 - ek[base+1];
        dk[6*r+2] = 16'd0 - ek[base+2];
      end else begin
        dk[6*r+1] = 16'd0 - ek[base+2];
        dk[6*r+2] = 16'd0 - ek[base+1];
      end
      dk[6*r+4] = ek[base-2];
      dk[6*r+5] = ek[base-1];
    end
    dk[6*rounds]   = minv(ek[0]);
    dk[6*rounds+1] = 16'd0 - ek[1];
    dk[6*rounds+2] = 16'd0 - ek[2];
    dk[6*rounds+3] = minv(ek[3]);
  endtask

  function automatic logic [63:0] ref_cipher(input logic [63:0] blk, input int rounds, input bit use1);
    logic [15:0] k [0:63];
    logic [15:0] x1, x2, x3, x4, a, b, c, d, t1, t2, t3;
    for (int i = 0; i < 64; i++) k[i] = use1 ? ks1[i] : ks8[i];
    {x1, x2, x3, x4} = blk;
    for (int r = 0; r < rounds; r++) begin
      a  = mmul(x1, k[6*r]);
      b  = x2 + k[6*r+1];
      c  = x3 + k[6*r+2];
      d  = mmul(x4, k[6*r+3]);
      t1 = mmul(a ^ c, k[6*r+4]);
      t2 = mmul((b ^ d) + t1, k[6*r+5]);
      t3 = t1 + t2;
      x1 = a ^ t2;
      x2 = c ^ t2;
      x3 = b ^ t3;
      x4 = d ^ t3;
    end
    return {mmul(x1, k[6*rounds]), 16'(x3 + k[6*rounds+1]),
            16'(x2 + k[6*rounds+2]), mmul(x4, k[6*rounds+3])};
  endfunction

  task automatic load8(input bit use_dec);
    for (int i = 0; i < 64; i++) ks8[i] = use_dec ? dk[i] : ek[i];
  endtask

  task automatic load1(input bit use_dec);
    for (int i = 0; i < 64; i++) ks1[i] = use_dec ? dk[i] : ek[i];
  endtask

  // Offers one block to the selected instance, returns the result, accept-to-valid latency
  // and the number of key_idx sequence errors.
  task automatic run_block(input logic [63:0] blk, output logic [63:0] res, output int lat,
                           output int seq_err, output bit timeout);
    int n, idx, nk;
    nk = sel1 ? 10 : 52;
    res = '0; lat = -1; seq_err = 0; timeout = 1'b0; idx = 0;
    @(negedge clk);
    tb_in_block = blk;
    tb_in_valid = 1'b1;
    n = 0;
    while (!v_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!v_in_ready) begin
      timeout = 1'b1;
      tb_in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 tb_in_valid = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (v_out_valid) break;
      if (v_busy) begin
        if (v_key_idx != 6'(idx)) seq_err++;
        idx++;
      end
    end
    if (!v_out_valid) begin
      timeout = 1'b1;
      return;
    end
    lat = n - 1;
    res = v_out_block;
    if (idx != nk) seq_err++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready8 got %b want 1", in_ready8); end
    n_checks++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8 got %b want 0", out_valid8); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8 got %b want 0", busy8); end
    n_checks++; if (key_idx8 !== 6'd0) begin n_fail++; $display("FAIL reset_key_idx8 got %0d want 0", key_idx8); end
    n_checks++; if (out_block8 !== 64'd0) begin n_fail++; $display("FAIL reset_out_block8 got %h want 0", out_block8); end
    n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready1 got %b want 1", in_ready1); end
    n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid1 got %b want 0", out_valid1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    rst_n = 1'b1;
  endtask

  task automatic test_standard_vector();
    logic [63:0] res; int lat, se; bit to;
    sel1 = 1'b0; tb_out_ready = 1'b1;
    gen_enc(STD_KEY); load8(1'b0);
    run_block(STD_PT, res, lat, se, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL std_timeout got timeout want completion"); end
    n_checks++; if (res !== STD_CT) begin n_fail++; $display("FAIL std_out_block got %h want %h", res, STD_CT); end
    n_checks++; if (res !== ref_cipher(STD_PT, 8, 1'b0)) begin n_fail++; $display("FAIL std_model got %h want %h", res, ref_cipher(STD_PT, 8, 1'b0)); end
    n_checks++; if (lat != 52) begin n_fail++; $display("FAIL std_latency got %0d want 52", lat); end
    n_checks++; if (se != 0) begin n_fail++; $display("FAIL std_key_idx_seq got %0d errors want 0", se); end
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin n_fail++; $display("FAIL std_after_handshake got valid=%b ready=%b want 0/1", out_valid8, in_ready8); end
  endtask

  task automatic test_zero_operand();
    logic [63:0] res; int lat, se; bit to;
    sel1 = 1'b1; tb_out_ready = 1'b1;
    for (int i = 0; i < 64; i++) ks1[i] = '0;
    run_block(64'd0, res, lat, se, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL zero_timeout got timeout want completion"); end
    n_checks++; if (res !== 64'd0) begin n_fail++; $display("FAIL zero_out_block got %h want 0", res); end
    n_checks++; if (res !== ref_cipher(64'd0, 1, 1'b1)) begin n_fail++; $display("FAIL zero_model got %h want %h", res, ref_cipher(64'd0, 1, 1'b1)); end
    n_checks++; if (lat != 10) begin n_fail++; $display("FAIL zero_latency got %0d want 10", lat); end
    n_checks++; if (se != 0) begin n_fail++; $display("FAIL zero_key_idx_seq got %0d errors want 0", se); end
    sel1 = 1'b0;
  endtask

  task automatic test_random_blocks();
    logic [63:0] blk, res, exp; int lat, se; bit to;
    tb_out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      gen_enc({$urandom, $urandom, $urandom, $urandom});
      load8(1'b0); load1(1'b0);
      if (t % 3 == 0) ks8[$urandom_range(0, 51)] = 16'd0;
      sel1 = (t % 2 == 1);
      blk = {$urandom, $urandom};
      exp = ref_cipher(blk, sel1 ? 1 : 8, sel1);
      run_block(blk, res, lat, se, to);
      n_checks++; if (res !== exp || to) begin n_fail++; $display("FAIL rand_block[%0d] got %h want %h", t, res, exp); end
      n_checks++; if (lat != (sel1 ? 10 : 52)) begin n_fail++; $display("FAIL rand_latency[%0d] got %0d want %0d", t, lat, sel1 ? 10 : 52); end
    end
    sel1 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [63:0] blk, res, exp; int lat, se; bit to;
    sel1 = 1'b0; tb_out_ready = 1'b0;
    gen_enc({$urandom, $urandom, $urandom, $urandom}); load8(1'b0);
    blk = {$urandom, $urandom};
    exp = ref_cipher(blk, 8, 1'b0);
    run_block(blk, res, lat, se, to);
    n_checks++; if (res !== exp || to) begin n_fail++; $display("FAIL bp_result got %h want %h", res, exp); end
    for (int i = 0; i < 20; i++) begin
      n_checks++; if (out_valid8 !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid8); end
      n_checks++; if (out_block8 !== exp) begin n_fail++; $display("FAIL bp_stable[%0d] got %h want %h", i, out_block8, exp); end
      n_checks++; if (in_ready8 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready8); end
      tb_in_valid = 1'($urandom_range(0, 1));
      tb_in_block = {$urandom, $urandom};
      @(negedge clk);
    end
    tb_in_valid = 1'b0;
    tb_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
        n_fail++; $display("FAIL bp_release[%0d] got valid=%b ready=%b busy=%b want 0/1/0", i, out_valid8, in_ready8, busy8);
      end
    end
    n_checks++; if (out_block8 !== exp) begin n_fail++; $display("FAIL bp_hold_after got %h want %h", out_block8, exp); end
  endtask

  task automatic test_decrypt();
    logic [63:0] p, c, res; int lat, se; bit to;
    sel1 = 1'b0; tb_out_ready = 1'b1;
    gen_enc(STD_KEY); gen_dec(8); load8(1'b1);
    run_block(STD_CT, res, lat, se, to);
    n_checks++; if (res !== STD_PT || to) begin n_fail++; $display("FAIL dec_std got %h want %h", res, STD_PT); end
    n_checks++; if (se != 0) begin n_fail++; $display("FAIL dec_key_idx_seq got %0d errors want 0", se); end
    for (int t = 0; t < 2; t++) begin
      sel1 = (t == 1);
      gen_enc({$urandom, $urandom, $urandom, $urandom});
      load8(1'b0); load1(1'b0);
      p = {$urandom, $urandom};
      c = ref_cipher(p, sel1 ? 1 : 8, sel1);
      gen_dec(sel1 ? 1 : 8);
      load8(1'b1); load1(1'b1);
      run_block(c, res, lat, se, to);
      n_checks++; if (res !== p || to) begin n_fail++; $display("FAIL dec_roundtrip[%0d] got %h want %h", t, res, p); end
    end
    sel1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] res; int n, lat, se; bit found, to;
    sel1 = 1'b0; tb_out_ready = 1'b1;
    gen_enc(STD_KEY); load8(1'b0);
    @(negedge clk);
    tb_in_block = {$urandom, $urandom};
    tb_in_valid = 1'b1;
    n = 0;
    while (!in_ready8 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 tb_in_valid = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 100) begin
      @(negedge clk); n++;
      if (busy8 && key_idx8 == 6'd26) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rstmid_reach got key_idx=%0d want 26", key_idx8); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl got ready=%b valid=%b busy=%b want 1/0/0", in_ready8, out_valid8, busy8);
    end
    n_checks++; if (key_idx8 !== 6'd0) begin n_fail++; $display("FAIL rstmid_key_idx got %0d want 0", key_idx8); end
    n_checks++; if (out_block8 !== 64'd0) begin n_fail++; $display("FAIL rstmid_out_block got %h want 0", out_block8); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(STD_PT, res, lat, se, to);
    n_checks++; if (res !== STD_CT || to) begin n_fail++; $display("FAIL rstmid_after got %h want %h", res, STD_CT); end
    n_checks++; if (lat != 52) begin n_fail++; $display("FAIL rstmid_latency got %0d want 52", lat); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b;
    int acc[$], hs[$];
    logic [63:0] outs[$];
    int cyc;
    sel1 = 1'b0; tb_out_ready = 1'b1;
    gen_enc({$urandom, $urandom, $urandom, $urandom}); load8(1'b0);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    @(negedge clk);
    @(negedge clk);
    tb_in_block = a;
    tb_in_valid = 1'b1;
    cyc = 0;
    while (hs.size() < 2 && cyc < 400) begin
      if (in_ready8) acc.push_back(cyc);
      else tb_in_block = (acc.size() > 0) ? b : a;
      if (out_valid8) begin
        hs.push_back(cyc);
        outs.push_back(out_block8);
      end
      @(negedge clk);
      cyc++;
    end
    tb_in_valid = 1'b0;
    n_checks++; if (acc.size() < 2 || hs.size() < 2) begin
      n_fail++; $display("FAIL b2b_counts got acc=%0d hs=%0d want >=2/2", acc.size(), hs.size());
    end else begin
      n_checks++; if (acc[1] != hs[0] + 1) begin n_fail++; $display("FAIL b2b_gap got accept@%0d want %0d", acc[1], hs[0] + 1); end
      n_checks++; if (hs[0] != acc[0] + 53) begin n_fail++; $display("FAIL b2b_lat0 got %0d want %0d", hs[0], acc[0] + 53); end
      n_checks++; if (hs[1] != acc[1] + 53) begin n_fail++; $display("FAIL b2b_lat1 got %0d want %0d", hs[1], acc[1] + 53); end
      n_checks++; if (outs[0] !== ref_cipher(a, 8, 1'b0)) begin n_fail++; $display("FAIL b2b_out0 got %h want %h", outs[0], ref_cipher(a, 8, 1'b0)); end
      n_checks++; if (outs[1] !== ref_cipher(b, 8, 1'b0)) begin n_fail++; $display("FAIL b2b_out1 got %h want %h", outs[1], ref_cipher(b, 8, 1'b0)); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ks8[i] = '0; ks1[i] = '0; ek[i] = '0; dk[i] = '0;
    end
    test_reset();
    test_standard_vector();
    test_zero_operand();
    test_random_blocks();
    test_backpressure();
    test_decrypt();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
